// File: rtl/robot_pkg.sv
// Shared types for the robot control path.
//   cmd_t       : decoded command from the control FSM outputs {Z1,Z2}
//   drv_state_t : motor driver FSM state (3-bit, exported on state_o)
//   decode_cmd  : maps {Z1,Z2} to a command; Z2 (brake) has priority
package robot_pkg;

  typedef enum logic [1:0] {
    CMD_STOP  = 2'd0,
    CMD_DRIVE = 2'd1,
    CMD_BRAKE = 2'd2
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    COAST = 3'd2,
    DEAD  = 3'd3,
    BRAKE = 3'd4
  } drv_state_t;

  function automatic cmd_t decode_cmd(input logic z1, input logic z2);
    if (z2)      return CMD_BRAKE;
    else if (z1) return CMD_DRIVE;
    else         return CMD_STOP;
  endfunction

endpackage

// File: rtl/robot_pwm_gen.sv
// Free-running PWM generator.
//   clk, reset : system clock, synchronous active-high reset
//   en         : gate; pwm is held low when en=0
//   duty       : compare value; pwm high while pwm_cnt < duty (duty=0 -> always low)
//   pwm        : PWM output
// Period is 2^PWM_BITS cycles; the counter wraps naturally.
module robot_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  assign pwm = en && (pwm_cnt < duty);

endmodule

// File: rtl/robot_motor_driver.sv
// H-bridge leg driver: ramped PWM high side, low-side brake, break-before-make
// dead time between the two.
//   clk, reset : system clock, synchronous active-high reset
//   Z1, Z2     : forward-drive and brake requests from the control FSM
//   hs_en      : high-side enable (PWM), only in DRIVE/COAST
//   ls_en      : low-side enable, only in BRAKE
//   duty       : current PWM duty
//   at_speed   : full duty reached while in DRIVE
//   state_o    : FSM state for debug
module robot_motor_driver
  import robot_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_STEP   = 16,
  parameter int RAMP_DIV    = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int BRAKE_MIN   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Z1,
  input  logic                Z2,
  output logic                hs_en,
  output logic                ls_en,
  output logic [PWM_BITS-1:0] duty,
  output logic                at_speed,
  output logic [2:0]          state_o
);

  localparam int RW = (RAMP_DIV    > 1) ? $clog2(RAMP_DIV)    : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int BW = (BRAKE_MIN   > 1) ? $clog2(BRAKE_MIN)   : 1;

  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [BW-1:0] BRK_LAST  = BW'(BRAKE_MIN - 1);

  // Saturating ramp arithmetic: duty never wraps in either direction.
  function automatic logic [PWM_BITS-1:0] sat_up(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] s;
    s = {1'b0, d} + (PWM_BITS+1)'(RAMP_STEP);
    if (s[PWM_BITS]) return '1;
    else             return s[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_down(input logic [PWM_BITS-1:0] d);
    if ({1'b0, d} <= (PWM_BITS+1)'(RAMP_STEP)) return '0;
    else                                       return d - PWM_BITS'(RAMP_STEP);
  endfunction

  cmd_t                cmd_p1;
  drv_state_t          state, state_nx;
  drv_state_t          target, target_nx;
  logic [PWM_BITS-1:0] duty_nx, duty_up, duty_dn;
  logic [RW-1:0]       ramp_cnt, ramp_nx;
  logic [DW-1:0]       dead_cnt, dead_nx;
  logic [BW-1:0]       brk_cnt, brk_nx;
  logic                ramp_step;
  logic                pwm;

  assign duty_up   = sat_up(duty);
  assign duty_dn   = sat_down(duty);
  assign ramp_step = (ramp_cnt == RAMP_LAST);

  // ---- Stage p1: registered command, FSM and counters ----
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_p1   <= CMD_STOP;
      state    <= IDLE;
      target   <= IDLE;
      duty     <= '0;
      ramp_cnt <= '0;
      dead_cnt <= '0;
      brk_cnt  <= '0;
    end else begin
      cmd_p1   <= decode_cmd(Z1, Z2);
      state    <= state_nx;
      target   <= target_nx;
      duty     <= duty_nx;
      ramp_cnt <= ramp_nx;
      dead_cnt <= dead_nx;
      brk_cnt  <= brk_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    duty_nx   = duty;
    ramp_nx   = ramp_cnt;
    dead_nx   = dead_cnt;
    brk_nx    = brk_cnt;
    case (state)
      IDLE: begin
        duty_nx = '0;
        if (cmd_p1 == CMD_DRIVE) begin
          state_nx = DRIVE;
          ramp_nx  = '0;
        end else if (cmd_p1 == CMD_BRAKE) begin
          // Nothing is conducting on the high side, so brake immediately.
          state_nx = BRAKE;
          brk_nx   = '0;
        end
      end
      DRIVE: begin
        if (cmd_p1 == CMD_BRAKE) begin
          state_nx  = DEAD;
          target_nx = BRAKE;
          duty_nx   = '0;
          dead_nx   = '0;
        end else if (cmd_p1 == CMD_STOP) begin
          state_nx = COAST;
          ramp_nx  = '0;
        end else begin
          ramp_nx = ramp_step ? '0 : ramp_cnt + RW'(1);
          if (ramp_step) duty_nx = duty_up;
        end
      end
      COAST: begin
        if (cmd_p1 == CMD_BRAKE) begin
          state_nx  = DEAD;
          target_nx = BRAKE;
          duty_nx   = '0;
          dead_nx   = '0;
        end else if (cmd_p1 == CMD_DRIVE) begin
          // Resume ramping from wherever the coast-down had reached.
          state_nx = DRIVE;
          ramp_nx  = '0;
        end else if (duty == '0) begin
          state_nx = IDLE;
        end else begin
          ramp_nx = ramp_step ? '0 : ramp_cnt + RW'(1);
          if (ramp_step) begin
            duty_nx = duty_dn;
            if (duty_dn == '0) state_nx = IDLE;
          end
        end
      end
      DEAD: begin
        // Commands are ignored here; the target state evaluates the next one.
        if (dead_cnt == DEAD_LAST) begin
          state_nx = target;
          ramp_nx  = '0;
          brk_nx   = '0;
        end else begin
          dead_nx = dead_cnt + DW'(1);
        end
      end
      BRAKE: begin
        if (brk_cnt != BRK_LAST) begin
          brk_nx = brk_cnt + BW'(1);
        end else if (cmd_p1 == CMD_STOP) begin
          state_nx = IDLE;
        end else if (cmd_p1 == CMD_DRIVE) begin
          state_nx  = DEAD;
          target_nx = DRIVE;
          dead_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        duty_nx  = '0;
      end
    endcase
  end

  // ---- Output stage: combinational decode of registered state ----
  robot_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk   (clk),
    .reset (reset),
    .en    ((state == DRIVE) || (state == COAST)),
    .duty  (duty),
    .pwm   (pwm)
  );

  assign hs_en    = pwm;
  assign ls_en    = (state == BRAKE);
  assign at_speed = (state == DRIVE) && (duty == '1);
  assign state_o  = state;

endmodule

// File: tb/tb_robot_motor_driver.sv
module tb_robot_motor_driver;
  import robot_pkg::*;

  localparam int STEP  = 16;
  localparam int DIV   = 4;
  localparam int DEADC = 2;
  localparam int BMIN  = 8;
  localparam int MAXD  = 255;
  localparam int PER   = 256;

  localparam int M_IDLE  = 0;
  localparam int M_DRIVE = 1;
  localparam int M_COAST = 2;
  localparam int M_DEAD  = 3;
  localparam int M_BRAKE = 4;

  localparam int C_STOP  = 0;
  localparam int C_DRIVE = 1;
  localparam int C_BRAKE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Z1 = 1'b0;
  logic       Z2 = 1'b0;
  logic       hs_en, ls_en, at_speed;
  logic [7:0] duty;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: elapsed time in current mode, plain-integer duty.
  int m_st   = M_IDLE;
  int m_duty = 0;
  int m_t    = 0;
  int m_tgt  = M_IDLE;
  int m_cmd  = C_STOP;
  int m_cyc  = 0;

  always #5 clk = ~clk;

  robot_motor_driver dut (
    .clk      (clk),
    .reset    (reset),
    .Z1       (Z1),
    .Z2       (Z2),
    .hs_en    (hs_en),
    .ls_en    (ls_en),
    .duty     (duty),
    .at_speed (at_speed),
    .state_o  (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] st_code(input int s);
    case (s)
      M_IDLE:  return 32'(IDLE);
      M_DRIVE: return 32'(DRIVE);
      M_COAST: return 32'(COAST);
      M_DEAD:  return 32'(DEAD);
      default: return 32'(BRAKE);
    endcase
  endfunction

  task automatic enter(input int s);
    m_st = s;
    m_t  = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int c;
    int nd;
    if (reset) begin
      m_st = M_IDLE; m_duty = 0; m_t = 0; m_tgt = M_IDLE; m_cmd = C_STOP; m_cyc = 0;
      return;
    end
    c = m_cmd;
    m_cmd = Z2 ? C_BRAKE : (Z1 ? C_DRIVE : C_STOP);
    m_cyc = (m_cyc + 1) % PER;
    case (m_st)
      M_IDLE: begin
        if (c == C_DRIVE)      enter(M_DRIVE);
        else if (c == C_BRAKE) enter(M_BRAKE);
        else                   m_t++;
      end
      M_DRIVE: begin
        if (c == C_BRAKE) begin
          m_tgt = M_BRAKE; m_duty = 0; enter(M_DEAD);
        end else if (c == C_STOP) begin
          enter(M_COAST);
        end else begin
          if (m_t % DIV == DIV - 1) m_duty = (m_duty + STEP > MAXD) ? MAXD : m_duty + STEP;
          m_t++;
        end
      end
      M_COAST: begin
        if (c == C_BRAKE) begin
          m_tgt = M_BRAKE; m_duty = 0; enter(M_DEAD);
        end else if (c == C_DRIVE) begin
          enter(M_DRIVE);
        end else if (m_duty == 0) begin
          enter(M_IDLE);
        end else if (m_t % DIV == DIV - 1) begin
          nd = m_duty - STEP;
          m_duty = (nd < 0) ? 0 : nd;
          if (m_duty == 0) enter(M_IDLE);
          else             m_t++;
        end else begin
          m_t++;
        end
      end
      M_DEAD: begin
        if (m_t == DEADC - 1) enter(m_tgt);
        else                  m_t++;
      end
      default: begin
        if (m_t >= BMIN - 1 && c == C_STOP) begin
          enter(M_IDLE);
        end else if (m_t >= BMIN - 1 && c == C_DRIVE) begin
          m_tgt = M_DRIVE; enter(M_DEAD);
        end else begin
          m_t++;
        end
      end
    endcase
  endtask

  task automatic tick();
    logic exp_hs;
    @(posedge clk);
    model_step();
    #1;
    exp_hs = ((m_st == M_DRIVE) || (m_st == M_COAST)) && (m_cyc < m_duty);
    check("state", 32'(state_o), st_code(m_st));
    check("duty", 32'(duty), 32'(m_duty));
    check("hs_en", 32'(hs_en), 32'(exp_hs));
    check("ls_en", 32'(ls_en), 32'(m_st == M_BRAKE));
    check("at_speed", 32'(at_speed), 32'((m_st == M_DRIVE) && (m_duty == MAXD)));
    check("no_shoot_through", 32'(hs_en & ls_en), 32'd0);
  endtask

  task automatic run(input logic z1, input logic z2, input int n);
    Z1 = z1;
    Z2 = z2;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    // ramp to full speed, brake through dead time, then stop
    run(1'b1, 1'b0, 80);
    run(1'b0, 1'b1, 20);
    run(1'b0, 1'b0, 20);
    // early release of brake: minimum brake time still held
    run(1'b0, 1'b1, 5);
    run(1'b0, 1'b0, 20);
    // brake then drive: dead time then ramp from 0
    run(1'b0, 1'b1, 6);
    run(1'b1, 1'b0, 30);
    run(1'b0, 1'b0, 40);
    // both requests: brake has priority, no dead time from IDLE
    run(1'b1, 1'b1, 12);
    run(1'b0, 1'b0, 15);
    // coast-down from 64, then coast interrupted at 32
    run(1'b1, 1'b0, 18);
    run(1'b0, 1'b0, 30);
    run(1'b1, 1'b0, 18);
    run(1'b0, 1'b0, 10);
    run(1'b1, 1'b0, 20);
    run(1'b0, 1'b0, 40);
    // reset in the middle of DRIVE at duty 128
    run(1'b1, 1'b0, 34);
    do_reset();
    // randomized command segments with occasional reset
    for (int i = 0; i < 80; i++) begin
      int c;
      c = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) do_reset();
      run(c[1], c[0], $urandom_range(1, 60));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
